// File: rtl/alu_seq_wb.sv
// Multi-cycle ALU execute stage feeding a downstream enable register.
// Logic, add/sub and shift ops finish one cycle after acceptance. MUL runs a
// shift-add loop over WIDTH cycles. Every write of res is marked by a
// one-cycle res_we pulse, which drives the downstream register enable.
module alu_seq_wb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] res,
  output logic             res_we,
  output logic             carry,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  // Current-state registers
  state_e                 state_q;
  op_e                    op_q;
  logic [2*WIDTH-1:0]     a_sh_q;   // operand A, shifted left each MUL step
  logic [WIDTH-1:0]       b_sh_q;   // operand B, shifted right each MUL step
  logic [2*WIDTH-1:0]     acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   busy_q;
  logic [WIDTH-1:0]       res_q;
  logic                   res_we_q;
  logic                   carry_q;
  logic                   zero_q;

  // Next-state values
  state_e                 state_d;
  op_e                    op_d;
  logic [2*WIDTH-1:0]     a_sh_d;
  logic [WIDTH-1:0]       b_sh_d;
  logic [2*WIDTH-1:0]     acc_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   busy_d;
  logic [WIDTH-1:0]       res_d;
  logic                   res_we_d;
  logic                   carry_d;
  logic                   zero_d;

  // Datapath helpers
  logic [WIDTH-1:0]       a_lo;
  logic [WIDTH:0]         sum_ext;
  logic [WIDTH:0]         diff_ext;
  logic [2*WIDTH-1:0]     mul_acc;

  assign a_lo     = a_sh_q[WIDTH-1:0];
  assign sum_ext  = {1'b0, a_lo} + {1'b0, b_sh_q};
  assign diff_ext = {1'b0, a_lo} - {1'b0, b_sh_q};
  // Accumulator including the current MUL step, so the last step can write it.
  assign mul_acc  = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;

  // Next-state and datapath decode
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    res_d    = res_q;
    res_we_d = 1'b0;
    carry_d  = carry_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op_e'(op);
          a_sh_d = {{WIDTH{1'b0}}, a};
          b_sh_d = b;
          busy_d = 1'b1;
          if (op_e'(op) == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin res_d = sum_ext[WIDTH-1:0];  carry_d = sum_ext[WIDTH];  end
          OP_SUB: begin res_d = diff_ext[WIDTH-1:0]; carry_d = diff_ext[WIDTH]; end
          OP_AND: begin res_d = a_lo & b_sh_q;       carry_d = 1'b0;            end
          OP_OR:  begin res_d = a_lo | b_sh_q;       carry_d = 1'b0;            end
          OP_XOR: begin res_d = a_lo ^ b_sh_q;       carry_d = 1'b0;            end
          OP_SHL: begin res_d = a_lo << 1;           carry_d = a_lo[WIDTH-1];   end
          OP_SHR: begin res_d = a_lo >> 1;           carry_d = a_lo[0];         end
          default: begin res_d = res_q;              carry_d = carry_q;         end
        endcase
        res_we_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      S_MUL: begin
        acc_d  = mul_acc;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d    = mul_acc[WIDTH-1:0];
          carry_d  = |mul_acc[2*WIDTH-1:WIDTH];
          res_we_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // The zero flag always tracks the value being written.
    if (res_we_d) zero_d = (res_d == '0);
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      res_q    <= '0;
      res_we_q <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      res_q    <= res_d;
      res_we_q <= res_we_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign res    = res_q;
  assign res_we = res_we_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_wb.sv
// Directed testbench for alu_seq_wb. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point.
module tb_alu_seq_wb;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] res;
  logic             res_we;
  logic             carry;
  logic             zero;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b100,
                         SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  alu_seq_wb #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .res    (res),
    .res_we (res_we),
    .carry  (carry),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed,
                       input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare all outputs in one call.
  task automatic check_all(input string tag, input logic exp_busy,
                           input logic exp_we, input logic [WIDTH-1:0] exp_res,
                           input logic exp_carry, input logic exp_zero);
    check({tag, ".busy"},   16'(busy),   16'(exp_busy));
    check({tag, ".res_we"}, 16'(res_we), 16'(exp_we));
    check({tag, ".res"},    16'(res),    16'(exp_res));
    check({tag, ".carry"},  16'(carry),  16'(exp_carry));
    check({tag, ".zero"},   16'(zero),   16'(exp_zero));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = ADD; a = '0; b = '0;
    tick(); tick();
    check_all("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_all("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 1. ADD F0+20 -> 10, carry 1
    start = 1'b1; op = ADD; a = 8'hF0; b = 8'h20;
    tick();
    check_all("add.accept", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    start = 1'b0; a = 8'h00; b = 8'h00;       // changes after acceptance
    tick();
    check_all("add.write", 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
    tick();
    check_all("add.hold", 1'b0, 1'b0, 8'h10, 1'b1, 1'b0);

    // 2. SUB 05-05 -> 00 zero; SUB 03-05 -> FE borrow
    start = 1'b1; op = SUB; a = 8'h05; b = 8'h05;
    tick();
    start = 1'b0;
    tick();
    check_all("sub_eq", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    start = 1'b1; op = SUB; a = 8'h03; b = 8'h05;
    tick();
    start = 1'b0;
    tick();
    check_all("sub_borrow", 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);

    // 3. MUL 0C*0B -> 84 after 8 edges, busy for 8 cycles
    start = 1'b1; op = MUL; a = 8'h0C; b = 8'h0B;
    tick();
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int i = 1; i < WIDTH; i++) begin
      check("mul1.busy", 16'(busy), 16'd1);
      check("mul1.we", 16'(res_we), 16'd0);
      tick();
    end
    check("mul1.busy_last", 16'(busy), 16'd1);
    tick();
    check_all("mul1.write", 1'b0, 1'b1, 8'h84, 1'b0, 1'b0);
    tick();
    check("mul1.we_drop", 16'(res_we), 16'd0);

    // 5. Reset on the 4th MUL cycle aborts with no res_we
    start = 1'b1; op = MUL; a = 8'h0F; b = 8'h0F;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort.busy_before", 16'(busy), 16'd1);
    reset = 1'b1;
    tick();
    check_all("abort.reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      check("abort.no_we", 16'(res_we), 16'd0);
    end
    start = 1'b1; op = ADD; a = 8'h01; b = 8'h01;
    tick();
    start = 1'b0;
    tick();
    check_all("add_after_abort", 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

    // 3b/4. MUL 20*10 -> 00 carry zero; an ADD start during busy is ignored
    start = 1'b1; op = MUL; a = 8'h20; b = 8'h10;
    tick();
    start = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (i == 2) begin
        start = 1'b1; op = ADD; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      check("mul2.we_quiet", 16'(res_we), 16'd0);
      tick();
    end
    start = 1'b0;
    tick();
    check_all("mul2.write", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    check_all("mul2.single_pulse", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    check_all("mul2.no_queue", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // 6. start held high, back-to-back ops in 2-cycle slots
    start = 1'b1; op = XOR; a = 8'hAA; b = 8'hFF;
    tick();
    check("b2b.xor_accept", 16'(busy), 16'd1);
    op = SHL; a = 8'h81; b = 8'h00;
    tick();
    check_all("b2b.xor", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    check_all("b2b.hold1", 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    op = SHR; a = 8'h81;
    tick();
    check_all("b2b.shl", 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    tick();
    check_all("b2b.hold2", 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    check_all("b2b.shr", 1'b0, 1'b1, 8'h40, 1'b1, 1'b0);
    tick();
    check_all("b2b.hold3", 1'b0, 1'b0, 8'h40, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
